// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF fetch and MEM load/store, DM priority
// Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [31:0]   perf_conflict_cnt,
    output logic [31:0]   perf_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          w_req_nxt;
    logic          w_we_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] w_wdata_nxt;
    logic          w_if_valid;
    logic          w_dm_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
        end
    end

    // Request fields only change on a grant, so the memory sees them stable until ack.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_mem_req;
        w_we_nxt    = r_mem_we;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (dm_req) begin
                    w_state_nxt = BUSY_D;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = dm_we;
                    w_addr_nxt  = dm_addr;
                    w_wdata_nxt = dm_wdata;
                end else if (if_req) begin
                    w_state_nxt = BUSY_I;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = if_addr;
                end else begin
                    w_req_nxt   = 1'b0;
                end
            end
            BUSY_D, BUSY_I: begin
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign w_if_valid = mem_ack & (r_state == BUSY_I);
    assign w_dm_valid = mem_ack & (r_state == BUSY_D);

    assign if_valid  = w_if_valid;
    assign dm_valid  = w_dm_valid;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign if_stall  = if_req & ~w_if_valid;
    assign dm_stall  = dm_req & ~w_dm_valid;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
            r_wait_cnt     <= '0;
        end else begin
            if ((r_state == IDLE) && dm_req && if_req && (r_conflict_cnt != 32'hFFFF_FFFF))
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if ((if_stall || dm_stall) && (r_wait_cnt != 32'hFFFF_FFFF))
                r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign perf_conflict_cnt = r_conflict_cnt;
    assign perf_wait_cnt     = r_wait_cnt;
`else
    assign perf_conflict_cnt = 32'd0;
    assign perf_wait_cnt     = 32'd0;
`endif

endmodule
